// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle divider: FSM encodings, step count
// and the {HI, LO} result packing.
package div_unit_pkg;

    localparam int DIV_STEPS = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_ZERO = 2'd1,
        DIV_BUSY = 2'd2,
        DIV_DONE = 2'd3
    } div_state_e;

    // HI holds the remainder, LO holds the quotient
    function automatic logic [63:0] pack_result(input logic [31:0] rem,
                                                input logic [31:0] quo);
        return {rem, quo};
    endfunction

endpackage

// File: rtl/div_unit_step.sv
// One radix-2 restoring division iteration: shift in a dividend bit, try to
// subtract the divisor, keep the difference only if it did not go negative.
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_rem,
    input  logic              i_bit,
    input  logic [DATA_W-1:0] i_divisor,
    output logic [DATA_W-1:0] o_rem,
    output logic              o_q
);

    logic [DATA_W:0] w_shifted;
    logic [DATA_W:0] w_trial;

    // Partial remainder is always below the divisor, so the trial fits in DATA_W+1 bits
    assign w_shifted = {i_rem, i_bit};
    assign w_trial   = w_shifted - {1'b0, i_divisor};
    assign o_q       = ~w_trial[DATA_W];
    assign o_rem     = o_q ? w_trial[DATA_W-1:0] : w_shifted[DATA_W-1:0];

endmodule

// File: rtl/div_unit.sv
// Multi-cycle 32-bit DIV/DIVU unit: operand latch, 32 restoring steps, one
// sign fix-up cycle, then a registered {remainder, quotient} with success_o.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_i,
    input  logic [DATA_W-1:0]   dividend_i,
    input  logic [DATA_W-1:0]   divider_i,
    input  logic                start_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                success_o
);

    localparam logic [4:0] LAST_STEP = 5'(DIV_STEPS - 1);

    div_state_e        r_state;
    div_state_e        w_state_next;
    logic [4:0]        r_cnt;
    logic              r_last;
    logic [DATA_W-1:0] r_dvd;
    logic [DATA_W-1:0] r_dvs;
    logic [DATA_W-1:0] r_rem;
    logic              r_neg_q;
    logic              r_neg_r;
    logic [63:0]       r_result;
    logic [DATA_W-1:0] w_rem_next;
    logic              w_q_bit;

    function automatic logic [DATA_W-1:0] abs_val(input logic signed [DATA_W-1:0] v);
        return v[DATA_W-1] ? DATA_W'(-v) : DATA_W'(v);
    endfunction

    function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v, input logic n);
        return n ? DATA_W'(~v + 1'b1) : v;
    endfunction

    div_step #(.DATA_W(DATA_W)) u_step (
        .i_rem     (r_rem),
        .i_bit     (r_dvd[DATA_W-1]),
        .i_divisor (r_dvs),
        .o_rem     (w_rem_next),
        .o_q       (w_q_bit)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            DIV_IDLE: if (start_i) w_state_next = (divider_i == '0) ? DIV_ZERO : DIV_BUSY;
            DIV_ZERO: w_state_next = DIV_DONE;
            DIV_BUSY: begin
                if (!start_i)    w_state_next = DIV_IDLE;
                else if (r_last) w_state_next = DIV_DONE;
            end
            DIV_DONE: if (!start_i) w_state_next = DIV_IDLE;
            default:  w_state_next = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= DIV_IDLE;
            r_cnt    <= '0;
            r_last   <= 1'b0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                DIV_IDLE: begin
                    if (start_i && divider_i != '0) begin
                        r_dvd   <= signed_i ? abs_val(dividend_i) : dividend_i;
                        r_dvs   <= signed_i ? abs_val(divider_i) : divider_i;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        r_last  <= 1'b0;
                        r_neg_q <= signed_i & (dividend_i[DATA_W-1] ^ divider_i[DATA_W-1]);
                        r_neg_r <= signed_i & dividend_i[DATA_W-1];
                    end
                end
                DIV_ZERO: r_result <= '0;
                DIV_BUSY: begin
                    // Quotient bits fill the dividend register from the LSB as it drains
                    if (start_i && !r_last) begin
                        r_rem <= w_rem_next;
                        r_dvd <= {r_dvd[DATA_W-2:0], w_q_bit};
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == LAST_STEP) r_last <= 1'b1;
                    end else if (start_i) begin
                        r_result <= pack_result(neg_if(r_rem, r_neg_r), neg_if(r_dvd, r_neg_q));
                    end
                end
                DIV_DONE: if (!start_i) r_result <= '0;
                default: ;
            endcase
        end
    end

    assign success_o = (r_state == DIV_DONE);
    assign result_o  = r_result;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, signed/unsigned results,
// divide-by-zero, abort, reset mid-operation and back-to-back requests.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_i;
    logic [31:0] dividend_i;
    logic [31:0] divider_i;
    logic        start_i;
    logic [63:0] result_o;
    logic        success_o;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    div_unit #(.DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .signed_i   (signed_i),
        .dividend_i (dividend_i),
        .divider_i  (divider_i),
        .start_i    (start_i),
        .result_o   (result_o),
        .success_o  (success_o)
    );

    // Raise start and count edges until success_o; lat=-1 if it never arrives.
    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           input logic scramble, output int lat, output logic [63:0] res);
        signed_i   = s;
        dividend_i = a;
        divider_i  = b;
        start_i    = 1'b1;
        lat        = -1;
        res        = '0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (scramble && k == 0) begin
                dividend_i = 32'h5A5A1234;
                divider_i  = 32'h00000003;
                signed_i   = ~s;
            end
            if (success_o) begin
                lat = k;
                res = result_o;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        start_i    = 1'b0;
        signed_i   = 1'b0;
        dividend_i = '0;
        divider_i  = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (success_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_success: got %b expected 0", success_o);
        end
        n_cmp++;
        if (result_o !== 64'h0) begin
            n_fail++; $display("FAIL reset_result: got %h expected 0", result_o);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned();
        int          lat;
        logic [63:0] res;
        run_div(1'b0, 32'd100, 32'd7, 1'b1, lat, res);
        n_cmp++;
        if (lat !== 33) begin
            n_fail++; $display("FAIL udiv_latency: got %0d expected 33", lat);
        end
        n_cmp++;
        if (res !== 64'h00000002_0000000E) begin
            n_fail++; $display("FAIL udiv_result: got %h expected 000000020000000e", res);
        end
        // start still held: DONE must persist with the same result
        @(posedge clk); #1;
        n_cmp++;
        if (success_o !== 1'b1 || result_o !== 64'h00000002_0000000E) begin
            n_fail++; $display("FAIL udiv_hold: got %b/%h expected 1/000000020000000e", success_o, result_o);
        end
        start_i = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (success_o !== 1'b0 || result_o !== 64'h0) begin
            n_fail++; $display("FAIL udiv_drop: got %b/%h expected 0/0", success_o, result_o);
        end
    endtask

    task automatic test_signed_table(input string name, input logic s[4],
                                     input logic [31:0] ta[4], input logic [31:0] tb[4],
                                     input logic [63:0] te[4], input int tl[4], input int n);
        int          lat;
        logic [63:0] res;
        for (int i = 0; i < n; i++) begin
            run_div(s[i], ta[i], tb[i], 1'b0, lat, res);
            n_cmp++;
            if (lat !== tl[i]) begin
                n_fail++; $display("FAIL %s_latency[%0d]: got %0d expected %0d", name, i, lat, tl[i]);
            end
            n_cmp++;
            if (res !== te[i]) begin
                n_fail++; $display("FAIL %s_result[%0d]: got %h expected %h", name, i, res, te[i]);
            end
            start_i = 1'b0;
            @(posedge clk); #1;
            n_cmp++;
            if (success_o !== 1'b0) begin
                n_fail++; $display("FAIL %s_drop[%0d]: got %b expected 0", name, i, success_o);
            end
        end
    endtask

    task automatic test_signed();
        test_signed_table("sdiv",
            '{1'b1, 1'b1, 1'b0, 1'b0},
            '{32'hFFFFFFF9, 32'd7, 32'd0, 32'd0},
            '{32'd2, 32'hFFFFFFFE, 32'd1, 32'd1},
            '{64'hFFFFFFFF_FFFFFFFD, 64'h00000001_FFFFFFFD, 64'h0, 64'h0},
            '{33, 33, 33, 33}, 2);
    endtask

    task automatic test_overflow();
        test_signed_table("ovf",
            '{1'b1, 1'b0, 1'b0, 1'b0},
            '{32'h80000000, 32'h80000000, 32'd0, 32'd0},
            '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd1},
            '{64'h00000000_80000000, 64'h80000000_00000000, 64'h0, 64'h0},
            '{33, 33, 33, 33}, 2);
    endtask

    task automatic test_div_zero();
        test_signed_table("dz",
            '{1'b0, 1'b1, 1'b0, 1'b0},
            '{32'd1234, 32'd1234, 32'd0, 32'd0},
            '{32'd0, 32'd0, 32'd1, 32'd1},
            '{64'h0, 64'h0, 64'h0, 64'h0},
            '{1, 1, 33, 33}, 2);
    endtask

    task automatic test_abort();
        int          lat;
        logic [63:0] res;
        signed_i   = 1'b0;
        dividend_i = 32'd1000;
        divider_i  = 32'd3;
        start_i    = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        start_i = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (success_o !== 1'b0 || result_o !== 64'h0) begin
            n_fail++; $display("FAIL abort_idle: got %b/%h expected 0/0", success_o, result_o);
        end
        run_div(1'b0, 32'd50, 32'd5, 1'b0, lat, res);
        n_cmp++;
        if (lat !== 33) begin
            n_fail++; $display("FAIL abort_recover_latency: got %0d expected 33", lat);
        end
        n_cmp++;
        if (res !== 64'h00000000_0000000A) begin
            n_fail++; $display("FAIL abort_recover_result: got %h expected 000000000000000a", res);
        end
        start_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int          lat;
        logic [63:0] res;
        signed_i   = 1'b0;
        dividend_i = 32'd1000;
        divider_i  = 32'd3;
        start_i    = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        rst     = 1'b1;
        start_i = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (success_o !== 1'b0 || result_o !== 64'h0) begin
            n_fail++; $display("FAIL midrst_outputs: got %b/%h expected 0/0", success_o, result_o);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        run_div(1'b0, 32'hFFFFFFFF, 32'h10, 1'b0, lat, res);
        n_cmp++;
        if (lat !== 33 || res !== 64'h0000000F_0FFFFFFF) begin
            n_fail++; $display("FAIL b2b_first: got %0d/%h expected 33/0000000f0fffffff", lat, res);
        end
        start_i = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (success_o !== 1'b0) begin
            n_fail++; $display("FAIL b2b_first_pulse: got %b expected 0", success_o);
        end
        run_div(1'b0, 32'd9, 32'd3, 1'b0, lat, res);
        n_cmp++;
        if (lat !== 33 || res !== 64'h00000000_00000003) begin
            n_fail++; $display("FAIL b2b_second: got %0d/%h expected 33/0000000000000003", lat, res);
        end
        start_i = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (success_o !== 1'b0 || result_o !== 64'h0) begin
            n_fail++; $display("FAIL b2b_second_pulse: got %b/%h expected 0/0", success_o, result_o);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_overflow();
        test_div_zero();
        test_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
